ir_queue: RTL and testbench

IR_QUEUE -- requirements
Module: ir_queue

---
 rtl/ir_queue.sv | 104 ++++++++++
 tb/tb_ir_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - instruction prefetch queue feeding a decoded instruction register
module ir_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] DATA,
    input  logic             IR_in,
    input  logic             advance,
    input  logic             flush,
    output logic [WIDTH-1:0] REG_OUT_IR,
    output logic             valid,
    output logic [3:0]       opcode_out,
    output logic             S,
    output logic [1:0]       shift,
    output logic [2:0]       rd_out_1,
    output logic [2:0]       rd_out_2,
    output logic [2:0]       rs_1,
    output logic [2:0]       rs_2,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int T = WIDTH - 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_ir;
    logic             r_valid;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign w_pop   = advance && !w_empty;
    assign w_push  = IR_in && (!w_full || w_pop);
    assign w_drop  = IR_in && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ir       <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_ir     <= r_mem[r_rd_ptr];
            end
            if (advance) begin
                r_valid <= !w_empty;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset; empty entries are never read out.
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_push) begin
            r_mem[r_wr_ptr] <= DATA;
        end
    end

    assign REG_OUT_IR = r_ir;
    assign valid      = r_valid;
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;
    assign overflow   = r_overflow;

    assign opcode_out = r_ir[T:T-3];
    assign S          = r_ir[T-4];
    assign shift      = r_ir[T-5:T-6];
    assign rd_out_2   = r_ir[T-4:T-6];
    assign rd_out_1   = r_ir[T-7:T-9];
    assign rs_1       = r_ir[T-10:T-12];
    assign rs_2       = r_ir[T-13:T-15];
endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - directed self-checking bench for ir_queue
module tb_ir_queue;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // 16-bit, DEPTH 4 instance
    logic [15:0] DATA = '0;
    logic IR_in = 0, advance = 0, flush = 0;
    logic [15:0] REG_OUT_IR;
    logic valid, S, full, empty, overflow;
    logic [3:0] opcode_out;
    logic [1:0] shift;
    logic [2:0] rd_out_1, rd_out_2, rs_1, rs_2, count;

    ir_queue #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .DATA(DATA), .IR_in(IR_in), .advance(advance),
        .flush(flush), .REG_OUT_IR(REG_OUT_IR), .valid(valid), .opcode_out(opcode_out),
        .S(S), .shift(shift), .rd_out_1(rd_out_1), .rd_out_2(rd_out_2), .rs_1(rs_1),
        .rs_2(rs_2), .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    // 24-bit, DEPTH 4 instance
    logic [23:0] w_DATA = '0;
    logic w_IR_in = 0, w_advance = 0, w_flush = 0;
    logic [23:0] w_IR;
    logic w_valid, w_S, w_full, w_empty, w_overflow;
    logic [3:0] w_opcode;
    logic [1:0] w_shift;
    logic [2:0] w_rd1, w_rd2, w_rs1, w_rs2, w_count;

    ir_queue #(.WIDTH(24), .DEPTH(4)) dut24 (
        .clk(clk), .reset(reset), .DATA(w_DATA), .IR_in(w_IR_in), .advance(w_advance),
        .flush(w_flush), .REG_OUT_IR(w_IR), .valid(w_valid), .opcode_out(w_opcode),
        .S(w_S), .shift(w_shift), .rd_out_1(w_rd1), .rd_out_2(w_rd2), .rs_1(w_rs1),
        .rs_2(w_rs2), .count(w_count), .full(w_full), .empty(w_empty), .overflow(w_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IR_in = 0; advance = 0; flush = 0; reset = 0;
        w_IR_in = 0; w_advance = 0; w_flush = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic push(input logic [15:0] d);
        DATA = d; IR_in = 1; advance = 0;
        tick();
        IR_in = 0;
    endtask

    task automatic pop();
        IR_in = 0; advance = 1;
        tick();
        advance = 0;
    endtask

    task automatic test_reset();
        IR_in = 1; advance = 1; DATA = 16'hFFFF;
        reset = 1;
        tick();
        idle();
        n_checks++;
        if (REG_OUT_IR !== 16'h0 || valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1 ||
            full !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got ir=%h v=%b c=%0d e=%b f=%b o=%b exp ir=0000 v=0 c=0 e=1 f=0 o=0",
                     REG_OUT_IR, valid, count, empty, full, overflow);
        end
    endtask

    task automatic test_decode();
        do_reset();
        push(16'hA5C3);
        n_checks++;
        if (valid !== 1'b0 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL decode_push got v=%b c=%0d exp v=0 c=1", valid, count);
        end
        pop();
        n_checks++;
        if (REG_OUT_IR !== 16'hA5C3 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL decode_ir got ir=%h v=%b exp ir=a5c3 v=1", REG_OUT_IR, valid);
        end
        n_checks++;
        if (opcode_out !== 4'hA || S !== 1'b0 || shift !== 2'b10 || rd_out_2 !== 3'b010 ||
            rd_out_1 !== 3'b111 || rs_1 !== 3'b000 || rs_2 !== 3'b011) begin
            n_fail++;
            $display("FAIL decode_fields got op=%h S=%b sh=%b rd2=%b rd1=%b rs1=%b rs2=%b exp op=a S=0 sh=10 rd2=010 rd1=111 rs1=000 rs2=011",
                     opcode_out, S, shift, rd_out_2, rd_out_1, rs_1, rs_2);
        end
    endtask

    task automatic test_fill_overflow();
        logic [15:0] words [5];
        words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        do_reset();
        for (int i = 0; i < 4; i++) push(words[i]);
        n_checks++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full got f=%b c=%0d o=%b e=%b exp f=1 c=4 o=0 e=0", full, count, overflow, empty);
        end
        push(words[4]);
        n_checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL fill_overflow got o=%b c=%0d exp o=1 c=4", overflow, count);
        end
        for (int i = 0; i < 4; i++) begin
            pop();
            n_checks++;
            if (REG_OUT_IR !== words[i] || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_order%0d got ir=%h v=%b exp ir=%h v=1", i, REG_OUT_IR, valid, words[i]);
            end
        end
        n_checks++;
        if (empty !== 1'b1 || count !== 3'd0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_drained got e=%b c=%0d o=%b exp e=1 c=0 o=1", empty, count, overflow);
        end
    endtask

    task automatic test_full_both();
        do_reset();
        for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i));
        DATA = 16'hBEEF; IR_in = 1; advance = 1;
        tick();
        idle();
        n_checks++;
        if (count !== 3'd4 || REG_OUT_IR !== 16'h0100 || overflow !== 1'b0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_both got c=%0d ir=%h o=%b v=%b exp c=4 ir=0100 o=0 v=1", count, REG_OUT_IR, overflow, valid);
        end
        for (int i = 0; i < 4; i++) pop();
        n_checks++;
        if (REG_OUT_IR !== 16'hBEEF || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL full_both_last got ir=%h e=%b exp ir=beef e=1", REG_OUT_IR, empty);
        end
    endtask

    task automatic test_empty_no_bypass();
        do_reset();
        push(16'h1234);
        pop();
        DATA = 16'h7E81; IR_in = 1; advance = 1;
        tick();
        idle();
        n_checks++;
        if (valid !== 1'b0 || count !== 3'd1 || REG_OUT_IR !== 16'h1234) begin
            n_fail++;
            $display("FAIL no_bypass got v=%b c=%0d ir=%h exp v=0 c=1 ir=1234", valid, count, REG_OUT_IR);
        end
        pop();
        n_checks++;
        if (REG_OUT_IR !== 16'h7E81 || valid !== 1'b1 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL no_bypass_pop got ir=%h v=%b c=%0d exp ir=7e81 v=1 c=0", REG_OUT_IR, valid, count);
        end
        pop();
        n_checks++;
        if (valid !== 1'b0 || REG_OUT_IR !== 16'h7E81) begin
            n_fail++;
            $display("FAIL empty_advance got v=%b ir=%h exp v=0 ir=7e81", valid, REG_OUT_IR);
        end
        tick();
        n_checks++;
        if (valid !== 1'b0 || count !== 3'd0 || REG_OUT_IR !== 16'h7E81) begin
            n_fail++;
            $display("FAIL idle_hold got v=%b c=%0d ir=%h exp v=0 c=0 ir=7e81", valid, count, REG_OUT_IR);
        end
    endtask

    task automatic test_flush_reset();
        do_reset();
        for (int i = 0; i < 4; i++) push(16'hC000 + 16'(i));
        push(16'hDEAD);
        pop();
        n_checks++;
        if (count !== 3'd3 || valid !== 1'b1 || overflow !== 1'b1 || REG_OUT_IR !== 16'hC000) begin
            n_fail++;
            $display("FAIL flush_setup got c=%0d v=%b o=%b ir=%h exp c=3 v=1 o=1 ir=c000", count, valid, overflow, REG_OUT_IR);
        end
        DATA = 16'hF00D; IR_in = 1; advance = 1; flush = 1;
        tick();
        idle();
        n_checks++;
        if (count !== 3'd0 || valid !== 1'b0 || overflow !== 1'b0 || empty !== 1'b1 || REG_OUT_IR !== 16'hC000) begin
            n_fail++;
            $display("FAIL flush_prio got c=%0d v=%b o=%b e=%b ir=%h exp c=0 v=0 o=0 e=1 ir=c000",
                     count, valid, overflow, empty, REG_OUT_IR);
        end
        push(16'h0AA0);
        pop();
        n_checks++;
        if (REG_OUT_IR !== 16'h0AA0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_restart got ir=%h v=%b exp ir=0aa0 v=1", REG_OUT_IR, valid);
        end
        for (int i = 0; i < 3; i++) push(16'hE000 + 16'(i));
        DATA = 16'hF00D; IR_in = 1; advance = 1; flush = 1; reset = 1;
        tick();
        idle();
        n_checks++;
        if (count !== 3'd0 || valid !== 1'b0 || REG_OUT_IR !== 16'h0000 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prio got c=%0d v=%b ir=%h e=%b exp c=0 v=0 ir=0000 e=1", count, valid, REG_OUT_IR, empty);
        end
    endtask

    task automatic test_wrap24();
        logic [23:0] d;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            d = {4'(k + 3), 4'(k), 4'(15 - k), 4'(k * 5), 8'(k * 17)};
            w_DATA = d; w_IR_in = 1;
            tick();
            w_IR_in = 0; w_advance = 1;
            tick();
            w_advance = 0;
            n_checks++;
            if (w_IR !== d || w_valid !== 1'b1 || w_count !== 3'd0 ||
                w_opcode !== d[23:20] || w_rs2 !== d[10:8] || w_rd1 !== d[16:14] || w_shift !== d[18:17]) begin
                n_fail++;
                $display("FAIL wrap%0d got ir=%h v=%b c=%0d op=%h rs2=%b rd1=%b sh=%b exp ir=%h v=1 c=0 op=%h rs2=%b rd1=%b sh=%b",
                         k, w_IR, w_valid, w_count, w_opcode, w_rs2, w_rd1, w_shift,
                         d, d[23:20], d[10:8], d[16:14], d[18:17]);
            end
        end
    endtask

    initial begin
        idle();
        tick();
        test_reset();
        test_decode();
        test_fill_overflow();
        test_full_both();
        test_empty_no_bypass();
        test_flush_reset();
        test_wrap24();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
